udma_tx_lin_arbiter: RTL and testbench
======================================

Name: udma_tx_lin_arbiter

Overview:
- Round-robin arbiter that shares the single uDMA L2 read port among the TX linear channels (UART, QSPIM data/cmd, I2C data/cmd, HyperBus).
- Tracks outstanding reads in an in-order ID FIFO and routes each L2 response back to the channel that issued it.
- Sits between the TX linear channel blocks and the L2 interconnect port of the uDMA core.
- Uses OBI-style req/gnt/rvalid handshakes on both sides.

Parameters:
- N_CH, 6, number of TX linear channels; equals the uDMA TX linear channel count (1 UART + 2 QSPIM + 2 I2C + 1 HyperBus).
- ADDR_W, 32, L2 address width.
- DATA_W, 32, L2 data width.
- MAX_OUT, 4, maximum outstanding L2 reads; also the ID FIFO depth; power of 2, at least 2.
- ID_W, $clog2(N_CH), channel index width (derived).

Ports:
- clk_i  in  1  system clock.
- rstn_i  in  1  asynchronous active-low reset.
- ch_req_i  in  N_CH  per-channel read request.
- ch_addr_i  in  N_CH*ADDR_W  per-channel address; channel k occupies bits [k*ADDR_W +: ADDR_W].
- ch_gnt_o  out  N_CH  per-channel grant, one-hot or zero.
- ch_rvalid_o  out  N_CH  per-channel response valid, one-hot or zero.
- ch_rdata_o  out  DATA_W  response data, shared by all channels.
- l2_req_o  out  1  L2 read request.
- l2_addr_o  out  ADDR_W  L2 address.
- l2_gnt_i  in  1  L2 grant.
- l2_rvalid_i  in  1  L2 response valid.
- l2_rdata_i  in  DATA_W  L2 response data.
- outstanding_o  out  $clog2(MAX_OUT)+1  number of reads in flight.
- err_o  out  1  sticky error flag; set when l2_rvalid_i arrives with no read outstanding.

Behaviour:
- Reset values (rstn_i low, asynchronous):
  - rr_ptr=0, lock=0, lock_id=0.
  - ID FIFO empty; outstanding_o=0; err_o=0.
  - All outputs 0.
- Eligibility:
  - eligible = |ch_req_i AND FIFO not full.
  - When the FIFO is full, l2_req_o=0 and all ch_gnt_o=0, even if l2_rvalid_i pops an entry in the same cycle. Full is evaluated on the registered count.
- Arbitration:
  - Combinational. The winner is the first asserted ch_req_i found by scanning from index rr_ptr upward, wrapping at N_CH-1 back to 0.
  - l2_req_o = eligible.
  - l2_addr_o = address of the winner.
- Lock (address stability):
  - If l2_req_o=1 and l2_gnt_i=0, the arbiter registers lock=1 and lock_id=winner.
  - While lock=1, the winner is forced to lock_id regardless of rr_ptr or other requests, so l2_addr_o is held stable until granted.
  - lock clears on the handshake.
- Handshake (l2_req_o & l2_gnt_i), same cycle:
  - ch_gnt_o[winner]=1 (zero-cycle grant passthrough).
  - Push winner into the ID FIFO.
  - rr_ptr <= winner+1, wrapping to 0 after N_CH-1.
- Channel request contract:
  - A channel holds ch_req_i and its address until granted.
  - Deasserting ch_req_i while locked is a protocol violation; behaviour is undefined and is not checked.
- Response path:
  - On l2_rvalid_i with the FIFO non-empty: pop head, drive ch_rvalid_o[head]=1 in the same cycle, ch_rdata_o = l2_rdata_i.
  - Responses are strictly in order; there is no added latency in either direction.
- Simultaneous push and pop in one cycle: count is unchanged, pointers advance.
- outstanding_o = FIFO count, registered.
  - Increments on push only, decrements on pop only, unchanged on both.
  - Range 0..MAX_OUT.
- Error case: l2_rvalid_i while the FIFO is empty:
  - No ch_rvalid_o asserted; err_o <= 1.
  - err_o stays set until reset.
- Single requester: a channel keeps winning back-to-back because the scan from rr_ptr wraps to it.
- Fairness: with all N_CH channels requesting continuously and l2_gnt_i=1, grants cycle 0,1,…,N_CH-1,0.
- Reset mid-transaction: in-flight IDs are discarded. Responses arriving after reset set err_o.

Test Plan:
- Fairness: all 6 ch_req_i high, l2_gnt_i=1, l2_rvalid_i one cycle after each grant -> ch_gnt_o sequence 0,1,2,3,4,5,0; each ch_rvalid_o matches the grant order; err_o=0.
- Lock: ch_req_i=6'b000100 with addr 0x1C00_0040, l2_gnt_i=0 for 3 cycles, ch0 asserts on cycle 2 -> l2_addr_o stays 0x1C00_0040; ch_gnt_o[2] on cycle 4; ch0 granted next; rr_ptr goes 3 then 1.
- Full stall: l2_gnt_i=1, no rvalid, 5 requests from ch1 -> 4 grants, then l2_req_o=0 and outstanding_o=4; one rvalid -> ch_rvalid_o[1]=1, outstanding_o=3, next request granted the following cycle.
- Simultaneous push/pop: outstanding_o=2, grant and rvalid in the same cycle -> outstanding_o stays 2; rvalid routed to the oldest ID.
- Spurious response: l2_rvalid_i=1 with nothing outstanding -> ch_rvalid_o=0, err_o=1, still 1 after 10 cycles.
- Reset mid-op: 3 reads outstanding, rstn_i pulsed low -> outputs 0 and outstanding_o=0 immediately; a later l2_rvalid_i sets err_o.

Source files
------------

// File: rtl/udma_tx_lin_arbiter.sv
// Round-robin arbiter sharing the uDMA L2 read port among TX linear channels.
// Outstanding read IDs are kept in order so responses return to their issuer.
module udma_tx_lin_arbiter #(
  parameter int N_CH    = 6,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4,
  parameter int ID_W    = $clog2(N_CH)
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [N_CH-1:0]          ch_req_i,
  input  logic [N_CH*ADDR_W-1:0]   ch_addr_i,
  output logic [N_CH-1:0]          ch_gnt_o,
  output logic [N_CH-1:0]          ch_rvalid_o,
  output logic [DATA_W-1:0]        ch_rdata_o,
  output logic                     l2_req_o,
  output logic [ADDR_W-1:0]        l2_addr_o,
  input  logic                     l2_gnt_i,
  input  logic                     l2_rvalid_i,
  input  logic [DATA_W-1:0]        l2_rdata_i,
  output logic [$clog2(MAX_OUT):0] outstanding_o,
  output logic                     err_o
);

  localparam int CNT_W = $clog2(MAX_OUT) + 1;
  localparam int PTR_W = $clog2(MAX_OUT);

  typedef enum logic {
    ST_FREE = 1'b0,
    ST_LOCK = 1'b1
  } st_e;

  st_e              st_q, st_d;
  logic             locked;
  logic [ID_W-1:0]  lock_id_q, lock_id_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  scan_id;
  logic             scan_hit;
  logic [ID_W-1:0]  winner;
  logic [ID_W-1:0]  fifo_q [MAX_OUT];
  logic [ID_W-1:0]  head;
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             full, empty;
  logic             eligible;
  logic             push, pop;

  function automatic logic [ID_W-1:0] wrap_add(
    input logic [ID_W-1:0] a,
    input int unsigned     b
  );
    int unsigned s;
    s = 32'(a) + b;
    return ID_W'(s % N_CH);
  endfunction

  assign full  = (cnt_q == CNT_W'(MAX_OUT));
  assign empty = (cnt_q == '0);

  // first requester at or after rr_ptr, wrapping
  always_comb begin
    scan_id  = rr_ptr_q;
    scan_hit = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (!scan_hit && ch_req_i[wrap_add(rr_ptr_q, unsigned'(i))]) begin
        scan_id  = wrap_add(rr_ptr_q, unsigned'(i));
        scan_hit = 1'b1;
      end
    end
  end

  assign winner   = locked ? lock_id_q : scan_id;
  assign eligible = (|ch_req_i) & ~full;
  assign push     = eligible & l2_gnt_i;
  assign pop      = l2_rvalid_i & ~empty;
  assign head     = fifo_q[rptr_q];

  // lock FSM: state register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      st_q      <= ST_FREE;
      lock_id_q <= '0;
    end else begin
      st_q      <= st_d;
      lock_id_q <= lock_id_d;
    end
  end

  // lock FSM: next state
  always_comb begin
    st_d      = st_q;
    lock_id_d = lock_id_q;
    unique case (st_q)
      ST_FREE: begin
        if (eligible && !l2_gnt_i) begin
          st_d      = ST_LOCK;
          lock_id_d = winner;
        end
      end
      ST_LOCK: begin
        if (push) st_d = ST_FREE;
      end
      default: st_d = ST_FREE;
    endcase
  end

  // lock FSM: outputs
  always_comb begin
    locked = (st_q == ST_LOCK);
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (push) rr_ptr_d = wrap_add(winner, 1);
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  assign err_d = err_q | (l2_rvalid_i & empty);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      rr_ptr_q <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      for (int i = 0; i < MAX_OUT; i++) fifo_q[i] <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      if (push) begin
        fifo_q[wptr_q] <= winner;
        wptr_q         <= wptr_q + PTR_W'(1);
      end
      if (pop) rptr_q <= rptr_q + PTR_W'(1);
    end
  end

  assign l2_req_o      = eligible;
  assign l2_addr_o     = eligible ?
                         ch_addr_i[int'(winner)*ADDR_W +: ADDR_W] : '0;
  assign ch_gnt_o      = push ? (N_CH'(1) << winner) : '0;
  assign ch_rvalid_o   = pop ? (N_CH'(1) << head) : '0;
  assign ch_rdata_o    = pop ? l2_rdata_i : '0;
  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_udma_tx_lin_arbiter.sv
// Bench for udma_tx_lin_arbiter: directed scenarios plus random traffic
// checked against a queue-based model of the arbitration and response rules.
module tb_udma_tx_lin_arbiter;

  localparam int N  = 6;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic [N-1:0]  req_v;
  logic [N*AW-1:0] addr_v;
  logic          gnt;
  logic          rv;
  logic [DW-1:0] rdata;
  logic [N-1:0]  ch_gnt;
  logic [N-1:0]  ch_rv;
  logic [DW-1:0] ch_rd;
  logic          l2_req;
  logic [AW-1:0] l2_addr;
  logic [2:0]    outst;
  logic          err;

  udma_tx_lin_arbiter dut (
    .clk_i         (clk),
    .rstn_i        (rstn),
    .ch_req_i      (req_v),
    .ch_addr_i     (addr_v),
    .ch_gnt_o      (ch_gnt),
    .ch_rvalid_o   (ch_rv),
    .ch_rdata_o    (ch_rd),
    .l2_req_o      (l2_req),
    .l2_addr_o     (l2_addr),
    .l2_gnt_i      (gnt),
    .l2_rvalid_i   (rv),
    .l2_rdata_i    (rdata),
    .outstanding_o (outst),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // reference model state
  int q[$];
  int rr = 0;
  bit locked = 0;
  int lock_ch = 0;
  bit m_err = 0;
  bit keep_req = 0;

  // snapshots of the last step, taken before the clock edge
  logic [N-1:0]  o_gnt, o_rv;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_rd;
  logic          o_req, o_err;
  logic [2:0]    o_out;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick();
    if (locked) return lock_ch;
    for (int i = 0; i < N; i++)
      if (req_v[(rr + i) % N]) return (rr + i) % N;
    return -1;
  endfunction

  task automatic step();
    int w;
    bit e_req, push, pop;
    logic [N-1:0]  e_gnt, e_rv;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_rd;
    #1;
    w      = pick();
    e_req  = (req_v != 0) && (q.size() < MO);
    push   = e_req && gnt;
    pop    = rv && (q.size() > 0);
    e_addr = '0;
    if (e_req) e_addr = addr_v[w*AW +: AW];
    e_gnt  = push ? N'(1 << w) : '0;
    e_rv   = pop ? N'(1 << q[0]) : '0;
    e_rd   = pop ? rdata : '0;
    o_gnt = ch_gnt; o_rv = ch_rv; o_addr = l2_addr; o_rd = ch_rd;
    o_req = l2_req; o_err = err; o_out = outst;
    chk("l2_req", 64'(l2_req), 64'(e_req));
    chk("l2_addr", 64'(l2_addr), 64'(e_addr));
    chk("ch_gnt", 64'(ch_gnt), 64'(e_gnt));
    chk("ch_rvalid", 64'(ch_rv), 64'(e_rv));
    chk("ch_rdata", 64'(ch_rd), 64'(e_rd));
    chk("outstanding", 64'(outst), 64'(q.size()));
    chk("err", 64'(err), 64'(m_err));
    @(posedge clk);
    if (rv && q.size() == 0) m_err = 1;
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back(w);
      rr = (w + 1) % N;
      locked = 0;
    end else if (e_req) begin
      locked = 1;
      lock_ch = w;
    end
    @(negedge clk);
    if (push && !keep_req) req_v[w] = 1'b0;
  endtask

  task automatic drain();
    req_v = '0;
    gnt = 1'b0;
    while (q.size() > 0) begin
      rv = 1'b1;
      step();
    end
    rv = 1'b0;
  endtask

  task automatic async_reset(input string tag);
    rstn = 1'b0;
    req_v = '0; gnt = 1'b0; rv = 1'b0;
    #1;
    chk({tag, "_out"}, 64'(outst), 64'd0);
    chk({tag, "_req"}, 64'(l2_req), 64'd0);
    chk({tag, "_gnt"}, 64'(ch_gnt), 64'd0);
    chk({tag, "_rv"}, 64'(ch_rv), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    q.delete(); rr = 0; locked = 0; m_err = 0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0;
    req_v = '0; gnt = 1'b0; rv = 1'b0; rdata = '0;
    for (int c = 0; c < N; c++) addr_v[c*AW +: AW] = $urandom;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out", 64'(outst), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_req", 64'(l2_req), 64'd0);
    chk("rst_addr", 64'(l2_addr), 64'd0);
    @(negedge clk);
    rstn = 1'b1;

    // fairness: all request, grant always, respond one cycle later
    keep_req = 1;
    req_v = '1;
    gnt = 1'b1;
    for (int k = 0; k < 7; k++) begin
      rv = (q.size() > 0);
      rdata = $urandom;
      step();
      chk("fair_gnt", 64'(o_gnt), 64'(1 << (k % N)));
      if (k > 0) chk("fair_rv", 64'(o_rv), 64'(1 << ((k - 1) % N)));
    end
    chk("fair_err", 64'(o_err), 64'd0);
    keep_req = 0;
    drain();

    // lock: ch2 waits three cycles, ch0 joins meanwhile
    addr_v[2*AW +: AW] = 32'h1C00_0040;
    addr_v[0 +: AW] = 32'h1C00_1000;
    req_v = 6'b000100;
    gnt = 1'b0;
    step();
    chk("lock_addr1", 64'(o_addr), 64'h1C00_0040);
    chk("lock_nogrant", 64'(o_gnt), 64'd0);
    req_v[0] = 1'b1;
    step();
    chk("lock_addr2", 64'(o_addr), 64'h1C00_0040);
    step();
    chk("lock_addr3", 64'(o_addr), 64'h1C00_0040);
    gnt = 1'b1;
    step();
    chk("lock_gnt2", 64'(o_gnt), 64'b000100);
    chk("lock_addr4", 64'(o_addr), 64'h1C00_0040);
    step();
    chk("lock_gnt0", 64'(o_gnt), 64'b000001);
    chk("lock_addr0", 64'(o_addr), 64'h1C00_1000);
    drain();

    // full stall: ch1 keeps requesting with no responses
    keep_req = 1;
    req_v = 6'b000010;
    gnt = 1'b1;
    for (int k = 0; k < MO; k++) begin
      step();
      chk("full_gnt", 64'(o_gnt), 64'b000010);
    end
    step();
    chk("full_req", 64'(o_req), 64'd0);
    chk("full_out", 64'(o_out), 64'd4);
    rv = 1'b1;
    rdata = 32'hCAFE_0001;
    step();
    chk("full_rv", 64'(o_rv), 64'b000010);
    chk("full_rd", 64'(o_rd), 64'hCAFE_0001);
    chk("full_req_pop", 64'(o_req), 64'd0);
    rv = 1'b0;
    step();
    chk("full_out3", 64'(o_out), 64'd3);
    chk("full_regnt", 64'(o_gnt), 64'b000010);
    keep_req = 0;
    drain();

    // simultaneous push and pop with two reads outstanding
    req_v = 6'b011000;
    gnt = 1'b1;
    step();
    step();
    req_v = 6'b100000;
    rv = 1'b1;
    rdata = 32'h5A5A_0003;
    step();
    chk("sim_out_before", 64'(o_out), 64'd2);
    chk("sim_rv", 64'(o_rv), 64'b001000);
    chk("sim_gnt", 64'(o_gnt), 64'b100000);
    req_v = '0; gnt = 1'b0; rv = 1'b0;
    step();
    chk("sim_out_after", 64'(o_out), 64'd2);
    drain();

    // spurious response
    rv = 1'b1;
    step();
    chk("spur_rv", 64'(o_rv), 64'd0);
    rv = 1'b0;
    repeat (10) step();
    chk("spur_err", 64'(o_err), 64'd1);

    // reset with reads in flight
    req_v = 6'b000111;
    gnt = 1'b1;
    repeat (3) step();
    chk("mid_out", 64'(o_out), 64'd2);
    async_reset("midrst");
    rv = 1'b1;
    step();
    rv = 1'b0;
    step();
    chk("midrst_err", 64'(o_err), 64'd1);
    async_reset("rst2");

    // random traffic honouring the hold-until-granted contract
    for (int n = 0; n < 400; n++) begin
      for (int c = 0; c < N; c++) begin
        if (!req_v[c] && $urandom_range(3) == 0) begin
          req_v[c] = 1'b1;
          addr_v[c*AW +: AW] = $urandom;
        end
      end
      gnt = ($urandom_range(2) != 0);
      rv = (q.size() > 0) && ($urandom_range(1) == 1);
      rdata = $urandom;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
